// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the 640x480@60 raster path.
package vga_pkg;
   typedef logic [9:0] coord_t;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;

   localparam int H_TOTAL_DEF = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
   localparam int V_TOTAL_DEF = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   // Coordinates are 10 bits wide, so neither axis may exceed this many positions.
   localparam int COORD_LIMIT = 1024;
endpackage

// File: rtl/vga_axis_counter.sv
// Wrap counter 0..MAX with enable; resets to MAX so the first enabled edge lands on 0.
// Exposes the next count combinationally so callers can register decodes in step with it.
import vga_pkg::*;

module vga_axis_counter #(
   parameter int unsigned MAX = 799
) (
   input  logic   vga_clk,
   input  logic   reset_n,
   input  logic   en,
   output coord_t cnt,
   output coord_t cnt_n,
   output logic   wrap
);
   localparam coord_t MAX_C = coord_t'(MAX);

   always_comb begin
      wrap  = en && (cnt == MAX_C);
      cnt_n = cnt;
      if (en) cnt_n = wrap ? '0 : cnt + coord_t'(1);
   end

   always_ff @(posedge vga_clk) begin
      if (!reset_n) cnt <= MAX_C;
      else          cnt <= cnt_n;
   end
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: DrawX/DrawY counters plus decodes, all registered and cycle-aligned; no backpressure.
// Optional VGA_FRAME_CNT_EN adds a 16-bit frame_count that reads 0 during the first frame after reset.
import vga_pkg::*;

module vga_timing_gen #(
   parameter int   H_VISIBLE   = H_VISIBLE_DEF,
   parameter int   H_FRONT     = H_FRONT_DEF,
   parameter int   H_SYNC      = H_SYNC_DEF,
   parameter int   H_BACK      = H_BACK_DEF,
   parameter int   V_VISIBLE   = V_VISIBLE_DEF,
   parameter int   V_FRONT     = V_FRONT_DEF,
   parameter int   V_SYNC      = V_SYNC_DEF,
   parameter int   V_BACK      = V_BACK_DEF,
   parameter logic SYNC_ACTIVE = 1'b0
) (
   input  logic       vga_clk,
   input  logic       reset_n,
   output logic [9:0] DrawX,
   output logic [9:0] DrawY,
   output logic       blank,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic       line_end
`ifdef VGA_FRAME_CNT_EN
   ,output logic [15:0] frame_count
`endif
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_timing
      $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit coordinate range");
   end

   localparam coord_t H_VIS_C  = coord_t'(H_VISIBLE);
   localparam coord_t V_VIS_C  = coord_t'(V_VISIBLE);
   localparam coord_t HS_BEG_C = coord_t'(H_VISIBLE + H_FRONT);
   localparam coord_t HS_END_C = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam coord_t VS_BEG_C = coord_t'(V_VISIBLE + V_FRONT);
   localparam coord_t VS_END_C = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam coord_t H_LAST_C = coord_t'(H_TOTAL - 1);

   coord_t hc, vc, hc_n, vc_n;
   logic   h_wrap, v_wrap;

   vga_axis_counter #(.MAX(H_TOTAL - 1)) u_hcnt (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .en      (1'b1),
      .cnt     (hc),
      .cnt_n   (hc_n),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(.MAX(V_TOTAL - 1)) u_vcnt (
      .vga_clk (vga_clk),
      .reset_n (reset_n),
      .en      (h_wrap),
      .cnt     (vc),
      .cnt_n   (vc_n),
      .wrap    (v_wrap)
   );

   assign DrawX = hc;
   assign DrawY = vc;

   // Decodes use the next coordinates so the registered outputs describe the same pixel as DrawX/DrawY.
   always_ff @(posedge vga_clk) begin
      if (!reset_n) begin
         blank       <= 1'b0;
         hsync       <= ~SYNC_ACTIVE;
         vsync       <= ~SYNC_ACTIVE;
         frame_start <= 1'b0;
         line_end    <= 1'b1;
      end else begin
         blank       <= (hc_n < H_VIS_C) && (vc_n < V_VIS_C);
         hsync       <= ((hc_n >= HS_BEG_C) && (hc_n < HS_END_C)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         vsync       <= ((vc_n >= VS_BEG_C) && (vc_n < VS_END_C)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
         frame_start <= v_wrap;
         line_end    <= (hc_n == H_LAST_C);
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge vga_clk) begin
      if (!reset_n)    frame_count <= 16'hFFFF;
      else if (v_wrap) frame_count <= frame_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default 640x480 instance plus a tiny active-high-sync instance that completes whole frames quickly.
module tb_vga_timing_gen;
   // Tiny raster for the second instance: 32 pixels x 17 lines.
   localparam int S_HV = 20, S_HF = 3, S_HS = 5, S_HB = 4;
   localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;
   localparam int S_FRAME = (S_HV + S_HF + S_HS + S_HB) * (S_VV + S_VF + S_VS + S_VB);
   localparam int D_FRAME = 800 * 525;

   typedef struct packed {
      logic [9:0]  x;
      logic [9:0]  y;
      logic        blank;
      logic        hs;
      logic        vs;
      logic        fs;
      logic        le;
      logic [15:0] fc;
   } exp_t;

   logic        vga_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [9:0]  d_x, d_y, s_x, s_y;
   logic        d_blank, d_hs, d_vs, d_fs, d_le;
   logic        s_blank, s_hs, s_vs, s_fs, s_le;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] d_fc, s_fc;
`endif

   int n_cmp = 0;
   int n_fail = 0;

   exp_t q_d[$];
   exp_t q_s[$];

   int          pos_d = D_FRAME - 1, pos_s = S_FRAME - 1;
   logic [15:0] fc_d = 16'hFFFF, fc_s = 16'hFFFF;

   always #5 vga_clk = ~vga_clk;

   vga_timing_gen u_dut_d (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y), .blank(d_blank),
      .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs), .line_end(d_le)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(d_fc)
`endif
   );

   vga_timing_gen #(
      .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
      .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB), .SYNC_ACTIVE(1'b1)
   ) u_dut_s (
      .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
      .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs), .line_end(s_le)
`ifdef VGA_FRAME_CNT_EN
      , .frame_count(s_fc)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a raster position is a linear index into the frame; everything follows from x/y ranges.
   function automatic exp_t ref_out(input int pos, input int hv, input int hf, input int hsw, input int hb,
                                    input int vv, input int vf, input int vsw, input logic act,
                                    input logic [15:0] fc);
      int   ht = hv + hf + hsw + hb;
      int   x  = pos % ht;
      int   y  = pos / ht;
      exp_t e;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < hv) && (y < vv);
      e.hs    = (x >= hv + hf && x < hv + hf + hsw) ? act : ~act;
      e.vs    = (y >= vv + vf && y < vv + vf + vsw) ? act : ~act;
      e.fs    = (pos == 0);
      e.le    = (x == ht - 1);
      e.fc    = fc;
      return e;
   endfunction

   task automatic tick(input logic r);
      #1 reset_n = r;
      @(posedge vga_clk);
      if (!r) begin
         pos_d = D_FRAME - 1; fc_d = 16'hFFFF;
         pos_s = S_FRAME - 1; fc_s = 16'hFFFF;
      end else begin
         pos_d = (pos_d + 1) % D_FRAME; if (pos_d == 0) fc_d = fc_d + 16'd1;
         pos_s = (pos_s + 1) % S_FRAME; if (pos_s == 0) fc_s = fc_s + 16'd1;
      end
      q_d.push_back(ref_out(pos_d, 640, 16, 96, 48, 480, 10, 2, 1'b0, fc_d));
      q_s.push_back(ref_out(pos_s, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, 1'b1, fc_s));
   endtask

   // Monitor: one expected entry per edge, compared half a cycle later.
   always @(negedge vga_clk) begin
      exp_t e;
      if (q_d.size() > 0) begin
         e = q_d.pop_front();
         chk("d_DrawX", d_x, e.x);        chk("d_DrawY", d_y, e.y);
         chk("d_blank", d_blank, e.blank); chk("d_hsync", d_hs, e.hs);
         chk("d_vsync", d_vs, e.vs);       chk("d_frame_start", d_fs, e.fs);
         chk("d_line_end", d_le, e.le);
`ifdef VGA_FRAME_CNT_EN
         chk("d_frame_count", d_fc, e.fc);
`endif
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         chk("s_DrawX", s_x, e.x);        chk("s_DrawY", s_y, e.y);
         chk("s_blank", s_blank, e.blank); chk("s_hsync", s_hs, e.hs);
         chk("s_vsync", s_vs, e.vs);       chk("s_frame_start", s_fs, e.fs);
         chk("s_line_end", s_le, e.le);
`ifdef VGA_FRAME_CNT_EN
         chk("s_frame_count", s_fc, e.fc);
`endif
      end
   end

   initial begin
      int   blank_cnt = 0, hs_low = 0, le_cnt = 0, le_x = 0, vs_cnt = 0, fs_cnt = 0;
      logic found = 1'b0;

      repeat (3) tick(1'b0);
      #4;
      chk("rst_DrawX", d_x, 799);   chk("rst_DrawY", d_y, 524);
      chk("rst_blank", d_blank, 0); chk("rst_hsync", d_hs, 1);
      chk("rst_vsync", d_vs, 1);    chk("rst_line_end", d_le, 1);

      // Release: one default line and three tiny frames side by side.
      for (int i = 0; i < 3 * S_FRAME; i++) begin
         tick(1'b1);
         #4;
         if (i == 0) begin
            chk("rel_DrawX", d_x, 0); chk("rel_DrawY", d_y, 0);
            chk("rel_blank", d_blank, 1); chk("rel_frame_start", d_fs, 1);
         end
         if (i < 800) begin
            if (d_blank) blank_cnt++;
            if (!d_hs) hs_low++;
            if (d_le) begin le_cnt++; le_x = int'(d_x); end
         end
         if (s_vs) vs_cnt++;
         if (s_fs) begin
            fs_cnt++;
            chk("s_frame_period", i % S_FRAME, 0);
`ifdef VGA_FRAME_CNT_EN
            chk("s_frame_count_seq", s_fc, i / S_FRAME);
`endif
         end
      end
      chk("line0_blank_cycles", blank_cnt, 640);
      chk("line0_hsync_cycles", hs_low, 96);
      chk("line0_line_end_cnt", le_cnt, 1);
      chk("line0_line_end_x", le_x, 799);
      chk("s_vsync_cycles", vs_cnt, 3 * S_VS * (S_HV + S_HF + S_HS + S_HB));
      chk("s_frame_starts", fs_cnt, 3);

      // Reset while the tiny raster is inside both sync pulses.
      for (int i = 0; i < 1000 && !found; i++) begin
         tick(1'b1);
         #4;
         found = s_hs && s_vs;
      end
      chk("sync_search", found, 1);
      tick(1'b0);
      #4;
      chk("midrst_hsync", s_hs, 0); chk("midrst_vsync", s_vs, 0);
      chk("midrst_DrawX", s_x, 31); chk("midrst_DrawY", s_y, 16);
      tick(1'b0);
      tick(1'b0);
      tick(1'b1);
      #4;
      chk("restart_DrawX", s_x, 0); chk("restart_DrawY", s_y, 0);
      chk("restart_frame_start", s_fs, 1);

      // Free run with occasional random reset bursts.
      for (int k = 0; k < 60000; k++) begin
         if ($urandom_range(0, 2999) == 0) repeat ($urandom_range(1, 4)) tick(1'b0);
         else tick(1'b1);
      end
      @(negedge vga_clk);
      #1;
      chk("q_d_drained", q_d.size(), 0);
      chk("q_s_drained", q_s.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
